// File: rtl/ttrng_harvester.sv
// Entropy harvester for the latch-network TRNG: synchronises raw lines, XOR-combines,
// optionally von Neumann debiases, packs bits into words and runs a repetition-count test.
module ttrng_harvester #(
  parameter int CHANNELS    = 4,
  parameter int OUT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int REP_LIMIT   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic                debias_en,
  input  logic                rd_req,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  output logic                health_fail
);

  localparam int CW = $clog2(OUT_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(OUT_W - 1);
  localparam logic [7:0]    REP_MAX  = 8'(REP_LIMIT);

  typedef enum logic {VN_IDLE, VN_HAVE_FIRST} vn_state_t;

  logic [CHANNELS-1:0] sync_reg [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (!rst_n) sync_reg[gi] <= '0;
        else if (gi == 0) sync_reg[gi] <= raw_in;
        else sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
      end
    end
  endgenerate

  logic c_bit;
  logic sample;
  assign c_bit  = ^sync_reg[SYNC_STAGES-1];
  assign sample = ena & ~health_fail;

  // Repetition-count health test on the combined bit, ahead of debiasing
  logic       last_reg;
  logic [7:0] rep_reg;
  logic [7:0] rep_next;
  logic       trip;

  always_comb begin
    rep_next = 8'd1;
    if (c_bit == last_reg) rep_next = (rep_reg == REP_MAX) ? REP_MAX : rep_reg + 8'd1;
  end
  assign trip = sample && (rep_next == REP_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= 1'b0;
      rep_reg  <= '0;
    end else if (sample) begin
      last_reg <= c_bit;
      rep_reg  <= rep_next;
    end
  end

  // Von Neumann pairing; a mode change abandons any half-collected pair
  vn_state_t vn_state_reg, vn_state_next;
  logic      first_reg, first_next;
  logic      debias_prev_reg;
  logic      vn_accept;

  always_comb begin
    vn_state_next = vn_state_reg;
    first_next    = first_reg;
    vn_accept     = 1'b0;
    if (debias_en != debias_prev_reg) begin
      vn_state_next = VN_IDLE;
    end else if (sample && debias_en) begin
      case (vn_state_reg)
        VN_IDLE: begin
          vn_state_next = VN_HAVE_FIRST;
          first_next    = c_bit;
        end
        default: begin
          vn_state_next = VN_IDLE;
          vn_accept     = (c_bit != first_reg);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vn_state_reg    <= VN_IDLE;
      first_reg       <= 1'b0;
      debias_prev_reg <= 1'b0;
    end else begin
      vn_state_reg    <= vn_state_next;
      first_reg       <= first_next;
      debias_prev_reg <= debias_en;
    end
  end

  logic accept;
  logic acc_bit;
  assign accept  = sample && !trip && (debias_en ? vn_accept : 1'b1);
  assign acc_bit = debias_en ? first_reg : c_bit;

  // Packing; a completed word that cannot load parks its last bit in pend_reg
  logic [OUT_W-2:0] shreg_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic             pend_reg;
  logic             pend_bit_reg;
  logic [OUT_W-1:0] word_new;
  logic [OUT_W-1:0] word_pend;
  logic             word_done;
  logic             load_new;
  logic             load_pend;

  assign word_new  = {shreg_reg, acc_bit};
  assign word_pend = {shreg_reg, pend_bit_reg};
  assign word_done = accept && !pend_reg && (bit_cnt_reg == LAST_BIT);
  assign load_new  = word_done && (!out_valid || rd_req);
  assign load_pend = pend_reg && rd_req && !health_fail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_reg    <= '0;
      bit_cnt_reg  <= '0;
      pend_reg     <= 1'b0;
      pend_bit_reg <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      health_fail  <= 1'b0;
    end else if (trip) begin
      health_fail <= 1'b1;
      out_valid   <= 1'b0;
    end else if (!health_fail) begin
      if (load_pend) begin
        out_data    <= word_pend;
        out_valid   <= 1'b1;
        bit_cnt_reg <= '0;
        pend_reg    <= 1'b0;
      end else if (load_new) begin
        out_data    <= word_new;
        out_valid   <= 1'b1;
        bit_cnt_reg <= '0;
        shreg_reg   <= word_new[OUT_W-2:0];
      end else begin
        if (rd_req && out_valid) out_valid <= 1'b0;
        if (word_done) begin
          pend_reg     <= 1'b1;
          pend_bit_reg <= acc_bit;
        end else if (accept && !pend_reg) begin
          shreg_reg   <= word_new[OUT_W-2:0];
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule
